// File: rtl/gray_pkg.sv
// Shared helpers for Gray-code counters: width limits, end value and code conversion.
package gray_pkg;

  localparam int MAX_WIDTH = 16;

  // Largest count representable in 'width' bits, returned zero-extended to MAX_WIDTH.
  function automatic logic [MAX_WIDTH-1:0] max_count(input int width);
    return MAX_WIDTH'((33'd1 << width) - 33'd1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR from the MSB down; zero-extended inputs decode correctly.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational binary-to-Gray stage placed in front of the Gray output register.
module gray_encode #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray[WIDTH-1] = bin[WIDTH-1];

  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
      assign gray[gi] = bin[gi] ^ bin[gi+1];
    end
  endgenerate

endmodule

// File: rtl/gray_counter_n.sv
// Up/down Gray-code counter with load, wrap or saturate ends, sticky flags and terminal-count pulse.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter bit WRAP  = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clr,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             FlagClr,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Bin,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Tc
);

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(max_count(WIDTH));
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] bin_reg, bin_next;
  logic [WIDTH-1:0] gray_reg, gray_next;
  logic             ovf_reg, ovf_next;
  logic             udf_reg, udf_next;
  logic             tc_reg, tc_next;

  always_comb begin
    bin_next = bin_reg;
    ovf_next = ovf_reg;
    udf_next = udf_reg;
    tc_next  = 1'b0;
    if (Clr) begin
      bin_next = ZERO;
      ovf_next = 1'b0;
      udf_next = 1'b0;
    end else begin
      if (FlagClr) begin
        ovf_next = 1'b0;
        udf_next = 1'b0;
      end
      if (Load) begin
        bin_next = LoadVal;
      end else if (En) begin
        // End-value events are applied after FlagClr so a coincident event wins.
        if (Dir) begin
          if (bin_reg == MAX) begin
            bin_next = WRAP ? ZERO : MAX;
            ovf_next = 1'b1;
            tc_next  = 1'b1;
          end else begin
            bin_next = bin_reg + ONE;
          end
        end else begin
          if (bin_reg == ZERO) begin
            bin_next = WRAP ? MAX : ZERO;
            udf_next = 1'b1;
            tc_next  = 1'b1;
          end else begin
            bin_next = bin_reg - ONE;
          end
        end
      end
    end
  end

  gray_encode #(.WIDTH(WIDTH)) u_encode (
    .bin  (bin_next),
    .gray (gray_next)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bin_reg  <= '0;
      gray_reg <= '0;
      ovf_reg  <= 1'b0;
      udf_reg  <= 1'b0;
      tc_reg   <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      ovf_reg  <= ovf_next;
      udf_reg  <= udf_next;
      tc_reg   <= tc_next;
    end
  end

  assign Output    = gray_reg;
  assign Bin       = bin_reg;
  assign Overflow  = ovf_reg;
  assign Underflow = udf_reg;
  assign Tc        = tc_reg;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n: wrap and saturate instances plus a 5-bit instance.
module tb_gray_counter_n;

  logic       Clk = 1'b0;
  logic       Reset_n, Clr, En, Dir, Load, FlagClr;
  logic [4:0] LoadVal;

  logic [2:0] w_out, w_bin, s_out, s_bin;
  logic [4:0] f_out, f_bin;
  logic       w_ovf, w_udf, w_tc, s_ovf, s_udf, s_tc, f_ovf, f_udf, f_tc;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  gray_counter_n #(.WIDTH(3), .WRAP(1'b1)) u_wrap (
    .Clk(Clk), .Reset_n(Reset_n), .Clr(Clr), .En(En), .Dir(Dir), .Load(Load),
    .LoadVal(LoadVal[2:0]), .FlagClr(FlagClr), .Output(w_out), .Bin(w_bin),
    .Overflow(w_ovf), .Underflow(w_udf), .Tc(w_tc)
  );

  gray_counter_n #(.WIDTH(3), .WRAP(1'b0)) u_sat (
    .Clk(Clk), .Reset_n(Reset_n), .Clr(Clr), .En(En), .Dir(Dir), .Load(Load),
    .LoadVal(LoadVal[2:0]), .FlagClr(FlagClr), .Output(s_out), .Bin(s_bin),
    .Overflow(s_ovf), .Underflow(s_udf), .Tc(s_tc)
  );

  gray_counter_n #(.WIDTH(5), .WRAP(1'b1)) u_w5 (
    .Clk(Clk), .Reset_n(Reset_n), .Clr(Clr), .En(En), .Dir(Dir), .Load(Load),
    .LoadVal(LoadVal), .FlagClr(FlagClr), .Output(f_out), .Bin(f_bin),
    .Overflow(f_ovf), .Underflow(f_udf), .Tc(f_tc)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  logic [2:0] up_gray [8];
  logic [2:0] prev_gray;

  initial begin
    up_gray = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    Reset_n = 1'b0; Clr = 1'b0; En = 1'b0; Dir = 1'b1; Load = 1'b0; FlagClr = 1'b0;
    LoadVal = '0;
    #2;
    check_val("rst_out", 32'(w_out), 0);
    check_val("rst_bin", 32'(w_bin), 0);
    check_val("rst_ovf", 32'(w_ovf), 0);
    check_val("rst_udf", 32'(w_udf), 0);
    check_val("rst_tc",  32'(w_tc),  0);
    #10;
    Reset_n = 1'b1;
    En = 1'b1; Dir = 1'b1;

    // Up-count wrap over the full 3-bit cycle
    prev_gray = w_out;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val($sformatf("up_out%0d", i), 32'(w_out), 32'(up_gray[i]));
      check_val($sformatf("up_onebit%0d", i), 32'($countones(w_out ^ prev_gray)), 1);
      check_val($sformatf("up_tc%0d", i), 32'(w_tc), 32'(i == 7));
      check_val($sformatf("up_ovf%0d", i), 32'(w_ovf), 32'(i == 7));
      prev_gray = w_out;
    end
    En = 1'b0;
    tick();
    check_val("hold_tc",  32'(w_tc),  0);
    check_val("hold_ovf", 32'(w_ovf), 1);
    check_val("hold_bin", 32'(w_bin), 0);

    // Clear, then down-count wrap from 0
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    check_val("clr_ovf", 32'(w_ovf), 0);
    En = 1'b1; Dir = 1'b0;
    tick();
    check_val("dn_bin", 32'(w_bin), 7);
    check_val("dn_out", 32'(w_out), 4);
    check_val("dn_udf", 32'(w_udf), 1);
    check_val("dn_tc",  32'(w_tc),  1);
    check_val("sat_dn_bin", 32'(s_bin), 0);
    check_val("sat_dn_tc",  32'(s_tc),  1);
    tick();
    check_val("dn2_bin", 32'(w_bin), 6);
    check_val("dn2_out", 32'(w_out), 5);
    check_val("dn2_tc",  32'(w_tc),  0);
    check_val("dn2_udf", 32'(w_udf), 1);

    // Saturate at MAX
    En = 1'b0; Load = 1'b1; LoadVal = 5'd7;
    tick();
    Load = 1'b0;
    check_val("sat_ld_bin", 32'(s_bin), 7);
    check_val("sat_ld_tc",  32'(s_tc),  0);
    check_val("sat_ld_ovf", 32'(s_ovf), 0);
    En = 1'b1; Dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("sat_bin%0d", i), 32'(s_bin), 7);
      check_val($sformatf("sat_out%0d", i), 32'(s_out), 4);
      check_val($sformatf("sat_tc%0d", i),  32'(s_tc),  1);
      check_val($sformatf("sat_ovf%0d", i), 32'(s_ovf), 1);
    end
    En = 1'b0;
    tick();
    check_val("sat_idle_tc", 32'(s_tc), 0);

    // Priority: Clr beats Load and En, then Load beats En
    Load = 1'b1; LoadVal = 5'd3;
    tick();
    check_val("pri_pre_bin", 32'(w_bin), 3);
    Clr = 1'b1; Load = 1'b1; LoadVal = 5'd5; En = 1'b1; Dir = 1'b1;
    tick();
    check_val("pri_clr_bin", 32'(w_bin), 0);
    check_val("pri_clr_ovf", 32'(w_ovf), 0);
    check_val("pri_clr_udf", 32'(w_udf), 0);
    Clr = 1'b0;
    tick();
    check_val("pri_ld_bin", 32'(w_bin), 5);
    check_val("pri_ld_out", 32'(w_out), 7);
    check_val("pri_ld_tc",  32'(w_tc),  0);

    // FlagClr racing an overflow event
    LoadVal = 5'd7; En = 1'b0;
    tick();
    Load = 1'b0; FlagClr = 1'b1; En = 1'b1; Dir = 1'b1;
    tick();
    check_val("race_ovf", 32'(w_ovf), 1);
    check_val("race_tc",  32'(w_tc),  1);
    check_val("race_bin", 32'(w_bin), 0);
    En = 1'b0;
    tick();
    FlagClr = 1'b0;
    check_val("fclr_ovf", 32'(w_ovf), 0);
    check_val("fclr_tc",  32'(w_tc),  0);

    // Async reset mid-count on the 5-bit instance
    Clr = 1'b1;
    tick();
    Clr = 1'b0; En = 1'b1; Dir = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    check_val("w5_bin13", 32'(f_bin), 13);
    check_val("w5_out13", 32'(f_out), 11);
    En = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    check_val("arst_bin", 32'(f_bin), 0);
    check_val("arst_out", 32'(f_out), 0);
    check_val("arst_ovf", 32'(f_ovf), 0);
    check_val("arst_udf", 32'(f_udf), 0);
    check_val("arst_tc",  32'(f_tc),  0);
    #1;
    Reset_n = 1'b1;
    En = 1'b1;
    tick();
    check_val("arst_resume_bin", 32'(f_bin), 1);
    check_val("arst_resume_out", 32'(f_out), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
